// File: rtl/irq_exc_ctrl_pkg.sv
// Shared definitions for the interrupt/exception controller and the decoder:
// pipeline redirect encodings, the controller FSM states and an index-width helper.
package irq_exc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  localparam logic [2:0] PCSRC_NONE = 3'b000;
  localparam logic [2:0] PCSRC_IRQ  = 3'b100;
  localparam logic [2:0] PCSRC_EXC  = 3'b101;

  // Width of a line index; a single line still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_exc_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the unmasked pending lines.
module prio_enc
  import irq_exc_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int IDX_W = idx_width(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception controller: edge-captures IRQ lines into pending, selects
// one request, and issues a single pipeline redirect per handler entry.
module irq_exc_ctrl
  import irq_exc_ctrl_pkg::*;
#(
  parameter int N_IRQ = 4,
  parameter int ID_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             exc_req,
  input  logic             slot_ok,
  input  logic             eret,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  output logic             take,
  output logic [2:0]       pcsrc,
  output logic [ID_W:0]    cause,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             busy,
  output logic             double_fault
);

  localparam int IDX_W = idx_width(N_IRQ);

  state_t           state_reg, state_next;
  logic [N_IRQ-1:0] irq_q_reg;
  logic [N_IRQ-1:0] pending_reg, pending_next;
  logic [N_IRQ-1:0] mask_reg;
  logic [N_IRQ-1:0] irq_edge, unmasked, clr;
  logic             sel_exc_reg, sel_exc_next;
  logic [ID_W-1:0]  sel_id_reg, sel_id_next;
  logic             df_reg;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_index;

  assign irq_edge = irq_in & ~irq_q_reg;
  assign unmasked = pending_reg & ~mask_reg;

  prio_enc #(
    .N_IRQ(N_IRQ),
    .IDX_W(IDX_W)
  ) u_prio_enc (
    .req  (unmasked),
    .valid(enc_valid),
    .index(enc_index)
  );

  // Gated by reset so an in-flight selection never redirects while being discarded.
  assign take = (state_reg == ST_REQ) & slot_ok & ~reset;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_clr
      assign clr[gi] = take & ~sel_exc_reg & (sel_id_reg == ID_W'(gi));
    end
  endgenerate

  // A new edge on the line being serviced wins over its clear.
  assign pending_next = (pending_reg & ~clr) | irq_edge;

  always_comb begin
    state_next   = state_reg;
    sel_exc_next = sel_exc_reg;
    sel_id_next  = sel_id_reg;
    case (state_reg)
      ST_IDLE: begin
        if (exc_req || enc_valid) begin
          state_next   = ST_REQ;
          sel_exc_next = exc_req;
          sel_id_next  = exc_req ? '0 : ID_W'(enc_index);
        end
      end
      ST_REQ: begin
        if (take) begin
          state_next = ST_SERVICE;
        end else if (exc_req && !sel_exc_reg) begin
          sel_exc_next = 1'b1;
          sel_id_next  = '0;
        end
      end
      ST_SERVICE: begin
        if (eret) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      irq_q_reg   <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
      sel_exc_reg <= 1'b0;
      sel_id_reg  <= '0;
      df_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      irq_q_reg   <= irq_in;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      sel_exc_reg <= sel_exc_next;
      sel_id_reg  <= sel_id_next;
      if ((state_reg == ST_SERVICE) && exc_req) df_reg <= 1'b1;
    end
  end

  assign pcsrc        = (state_reg != ST_REQ) ? PCSRC_NONE :
                        (sel_exc_reg ? PCSRC_EXC : PCSRC_IRQ);
  assign cause        = (state_reg == ST_REQ) ? {sel_exc_reg, sel_id_reg} : '0;
  assign pending      = pending_reg;
  assign mask         = mask_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign double_fault = df_reg;

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Directed bench for irq_exc_ctrl: expected redirects are queued as stimulus is
// driven and popped when the controller raises take.
module tb_irq_exc_ctrl;
  import irq_exc_ctrl_pkg::*;

  localparam int N_IRQ = 4;
  localparam int ID_W  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_IRQ-1:0] irq_in;
  logic             exc_req;
  logic             slot_ok;
  logic             eret;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             take;
  logic [2:0]       pcsrc;
  logic [ID_W:0]    cause;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             busy;
  logic             double_fault;

  typedef struct {
    string         tag;
    logic [2:0]    pcsrc;
    logic [ID_W:0] cause;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  irq_exc_ctrl #(
    .N_IRQ(N_IRQ),
    .ID_W (ID_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .exc_req     (exc_req),
    .slot_ok     (slot_ok),
    .eret        (eret),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .take        (take),
    .pcsrc       (pcsrc),
    .cause       (cause),
    .pending     (pending),
    .mask        (mask),
    .busy        (busy),
    .double_fault(double_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [2:0] pc, input logic [ID_W:0] cs);
    exp_t e;
    e.tag   = tag;
    e.pcsrc = pc;
    e.cause = cs;
    sb_q.push_back(e);
  endtask

  // One clock: inspect take mid-cycle, then advance past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (take === 1'b1) begin
      n_tests++;
      assert (sb_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_take: observed take=1 pcsrc=%0h cause=%0h expected no take", pcsrc, cause);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk({e.tag, "_pcsrc"}, 32'(pcsrc), 32'(e.pcsrc));
        chk({e.tag, "_cause"}, 32'(cause), 32'(e.cause));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; exc_req = 1'b0; slot_ok = 1'b0;
    eret = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_take", 32'(take), 0);
    chk("rst_pcsrc", 32'(pcsrc), 0);
    chk("rst_cause", 32'(cause), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask", 32'(mask), 0);
    chk("rst_df", 32'(double_fault), 0);

    // Single IRQ on line 2: pending next cycle, take the cycle after.
    slot_ok = 1'b1;
    irq_in = 4'b0100;
    push_exp("irq2", PCSRC_IRQ, 5'b0_0010);
    step();
    chk("irq2_pending_set", 32'(pending), 32'h4);
    chk("irq2_idle_busy", 32'(busy), 0);
    step();
    chk("irq2_req_busy", 32'(busy), 1);
    step();
    chk("irq2_pending_clr", 32'(pending), 0);
    chk("irq2_service_pcsrc", 32'(pcsrc), 0);
    irq_in = '0; eret = 1'b1;
    step();
    eret = 1'b0;
    chk("irq2_eret_busy", 32'(busy), 0);
    chk("irq2_sb_empty", 32'(sb_q.size()), 0);

    // Lines 1 and 3 together with line 1 masked: only line 3 serviced.
    mask_we = 1'b1; mask_wdata = 4'b0010;
    step();
    mask_we = 1'b0;
    chk("mask_write", 32'(mask), 32'h2);
    irq_in = 4'b1010;
    push_exp("irq3", PCSRC_IRQ, 5'b0_0011);
    step();
    chk("pair_pending", 32'(pending), 32'hA);
    step(); step();
    chk("pair_after_take", 32'(pending), 32'h2);
    eret = 1'b1;
    step();
    eret = 1'b0;
    step(); step(); step();
    chk("masked_still_pending", 32'(pending), 32'h2);
    chk("masked_idle", 32'(busy), 0);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    push_exp("irq1_unmasked", PCSRC_IRQ, 5'b0_0001);
    step();
    mask_we = 1'b0;
    step(); step();
    chk("irq1_cleared", 32'(pending), 0);
    eret = 1'b1;
    step();
    eret = 1'b0; irq_in = '0;
    step();
    chk("pair_sb_empty", 32'(sb_q.size()), 0);

    // Exception arriving while IRQ 1 waits for a slot upgrades the selection.
    slot_ok = 1'b0;
    irq_in = 4'b0010;
    step(); step();
    chk("upg_pcsrc_irq", 32'(pcsrc), 32'(PCSRC_IRQ));
    chk("upg_cause_irq", 32'(cause), 32'h01);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    chk("upg_pcsrc_exc", 32'(pcsrc), 32'(PCSRC_EXC));
    chk("upg_cause_exc", 32'(cause), 32'h10);
    slot_ok = 1'b1;
    push_exp("exc_upg", PCSRC_EXC, 5'b1_0000);
    step();
    chk("upg_irq1_kept", 32'(pending), 32'h2);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("upg_one_idle", 32'(busy), 0);
    push_exp("irq1_after_exc", PCSRC_IRQ, 5'b0_0001);
    step(); step();
    eret = 1'b1;
    step();
    eret = 1'b0; irq_in = '0;
    step();
    chk("upg_sb_empty", 32'(sb_q.size()), 0);

    // Exception inside a handler: double fault, no redirect, sticky past eret.
    irq_in = 4'b0001;
    push_exp("irq0", PCSRC_IRQ, 5'b0_0000);
    step(); step(); step();
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    chk("df_set", 32'(double_fault), 1);
    chk("df_busy", 32'(busy), 1);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("df_sticky", 32'(double_fault), 1);
    chk("df_idle", 32'(busy), 0);
    irq_in = '0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("df_reset", 32'(double_fault), 0);
    chk("df_sb_empty", 32'(sb_q.size()), 0);

    // Reset during REQ with no slot discards the selection.
    slot_ok = 1'b0;
    irq_in = 4'b0100;
    step(); step();
    chk("rq_busy", 32'(busy), 1);
    irq_in = '0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rq_rst_busy", 32'(busy), 0);
    chk("rq_rst_pending", 32'(pending), 0);
    chk("rq_rst_take", 32'(take), 0);
    slot_ok = 1'b1;
    step(); step();
    chk("rq_no_take_busy", 32'(busy), 0);

    // Mask write and edge on the same line in the same cycle.
    mask_we = 1'b1; mask_wdata = 4'b1000; irq_in = 4'b1000;
    step();
    mask_we = 1'b0;
    chk("mw_pending", 32'(pending), 32'h8);
    chk("mw_mask", 32'(mask), 32'h8);
    step(); step(); step();
    chk("mw_not_taken", 32'(busy), 0);
    chk("final_sb_empty", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_exc_ctrl.md
IRQ_EXC_CTRL -- requirements
Module: irq_exc_ctrl

Interface
REQ-001 SHALL have parameter N_IRQ, default 4: number of external interrupt lines, range 1..16.
REQ-002 SHALL have parameter ID_W, default 4: width of the source-id field of cause.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port irq_in, input, N_IRQ: level interrupt lines, synchronous to clk.
REQ-006 SHALL have port exc_req, input, 1: level, illegal-opcode exception from the decoder.
REQ-007 SHALL have port slot_ok, input, 1: pipeline can redirect this cycle (no stall, no branch delay slot).
REQ-008 SHALL have port eret, input, 1: one-cycle pulse when a handler return retires.
REQ-009 SHALL have port mask_we, input, 1, and port mask_wdata, input, N_IRQ: mask write; bit=1 masks the line.
REQ-010 SHALL have port take, output, 1: redirect strobe to the pipeline.
REQ-011 SHALL have port pcsrc, output, 3: 3'b100 IRQ, 3'b101 exception, 3'b000 none.
REQ-012 SHALL have port cause, output, ID_W+1: {is_exc, source id}.
REQ-013 SHALL have ports pending (N_IRQ), mask (N_IRQ), busy (1) and double_fault (1), all outputs.

Function
REQ-014 SHALL register irq_in into irq_q every cycle; edge = irq_in & ~irq_q.
REQ-015 SHALL set pending[i] on edge[i] at the same clock edge, so pending is visible the cycle after irq_in first reads high.
REQ-016 SHALL clear pending[i] only on the take edge that services line i; a simultaneous edge[i] keeps it set.
REQ-017 SHALL update mask on mask_we; the new mask takes effect from the next cycle.
REQ-018 SHALL implement FSM IDLE, REQ, SERVICE, with IDLE as the reset state.
REQ-019 IDLE->REQ SHALL occur when exc_req is high, or when (pending & ~mask) is nonzero.
REQ-020 On entry to REQ, the selection SHALL latch: exception if exc_req is high, else the lowest-index unmasked pending line.
REQ-021 In REQ, if exc_req rises while an IRQ is selected, the selection SHALL upgrade to the exception; IRQ selection SHALL NOT change otherwise.
REQ-022 take SHALL be asserted combinationally as (state==REQ) & slot_ok; REQ persists with no timeout while slot_ok is low.
REQ-023 On the take edge, the FSM SHALL go REQ->SERVICE.
REQ-024 pcsrc and cause SHALL reflect the latched selection while in REQ, and SHALL read 0 in IDLE and SERVICE.
REQ-025 SERVICE->IDLE SHALL occur on eret; eret SHALL be ignored in IDLE and REQ.
REQ-026 On SERVICE->IDLE, re-entry to REQ SHALL take at least one IDLE cycle.
REQ-027 exc_req high in SERVICE SHALL set double_fault; double_fault is sticky until reset.
REQ-028 exc_req high in SERVICE SHALL NOT cause a take.
REQ-029 IRQ edges in SERVICE SHALL accumulate in pending.
REQ-030 busy SHALL equal (state != IDLE).
REQ-031 For N_IRQ < 2^ID_W, the id SHALL be zero-extended; the id for an exception SHALL be 0.

Reset
REQ-032 On reset, state, pending, mask, irq_q and double_fault SHALL be 0, and the FSM SHALL be in IDLE.
REQ-033 On reset, take, pcsrc, cause and busy SHALL read 0 from the cycle after reset is sampled.
REQ-034 Reset asserted in any state SHALL discard the in-flight selection without producing take.

Structure
REQ-035 The PCSRC_* encodings and the FSM state enum SHALL live in the shared package, also used by the decoder.
REQ-036 The priority encoder SHALL be a sub-module prio_enc, parametrised by N_IRQ and producing a valid bit and an index.

Verification
REQ-037 irq_in[2] rises at cycle 10, slot_ok=1 -> pending[2] set at cycle 11, take at cycle 12 with pcsrc=100 and cause=0_0010, pending[2] cleared at cycle 13.
REQ-038 irq_in=4'b1010 rising together, mask=4'b0010 -> line 3 is serviced first; after eret, line 1 stays pending and is not taken until the mask is written to 0.
REQ-039 In REQ with IRQ 1 selected and slot_ok=0, exc_req rises -> take occurs when slot_ok=1, with pcsrc=101 and cause=1_0000.
REQ-040 exc_req=1 in SERVICE -> double_fault=1 with no take; double_fault persists after eret; reset clears it.
REQ-041 Reset pulsed during REQ with slot_ok=0 -> next cycle state=IDLE, pending=0 and take never asserted.
REQ-042 Mask write and edge on the same line in the same cycle -> the line becomes pending but is not taken while masked.
